// File: rtl/taxi_dma_wr_desc_split.sv
// Write-descriptor splitter placed in front of the AXI write DMA.
// It breaks one parent descriptor into segments that never cross a
// 2**SEG_LEN_W-byte destination boundary, and it limits how many segments
// can be issued but not yet completed. It merges the segment statuses and
// returns a single status for each parent.
module taxi_dma_wr_desc_split #(
    parameter int SRC_ADDR_W      = 16,
    parameter int SRC_SEL_W       = 2,
    parameter int DST_ADDR_W      = 16,
    parameter int LEN_W           = 16,
    parameter int TAG_W           = 8,
    parameter int SEG_LEN_W       = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [SRC_ADDR_W-1:0] s_req_src_addr,
    input  logic [SRC_SEL_W-1:0]  s_req_src_sel,
    input  logic [DST_ADDR_W-1:0] s_req_dst_addr,
    input  logic [LEN_W-1:0]      s_req_len,
    input  logic [TAG_W-1:0]      s_req_tag,
    input  logic                  s_req_valid,
    output logic                  s_req_ready,

    output logic [TAG_W-1:0]      s_sts_tag,
    output logic [3:0]            s_sts_error,
    output logic                  s_sts_valid,

    output logic [SRC_ADDR_W-1:0] m_req_src_addr,
    output logic [SRC_SEL_W-1:0]  m_req_src_sel,
    output logic [DST_ADDR_W-1:0] m_req_dst_addr,
    output logic [LEN_W-1:0]      m_req_len,
    output logic [TAG_W-1:0]      m_req_tag,
    output logic                  m_req_valid,
    input  logic                  m_req_ready,

    input  logic [3:0]            m_sts_error,
    input  logic                  m_sts_valid
);

    localparam int SW    = SEG_LEN_W + 1;
    localparam int LW1   = LEN_W + 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state;
    logic [SRC_ADDR_W-1:0] src_ptr;
    logic [DST_ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]      rem;
    logic [TAG_W-1:0]      tag_reg;
    logic [SRC_SEL_W-1:0]  sel_reg;
    logic [3:0]            err_reg;
    logic [CNT_W-1:0]      cnt;

    logic [SW-1:0]         space;
    logic [SW-1:0]         seg;
    logic                  hs;
    logic                  sts_ok;
    logic [CNT_W-1:0]      cnt_next;
    logic [3:0]            err_next;

    // Compute the next segment size, the outstanding count and the merged error.
    always_comb begin
        space    = (SW'(1) << SEG_LEN_W) - SW'(dst_ptr[SEG_LEN_W-1:0]);
        seg      = (LW1'(rem) < LW1'(space)) ? SW'(rem) : space;
        hs       = m_req_valid & m_req_ready;
        // A status that arrives with nothing in flight is stale and is dropped.
        sts_ok   = m_sts_valid && (cnt != '0);
        cnt_next = cnt + CNT_W'(hs) - CNT_W'(sts_ok);
        err_next = (sts_ok && err_reg == 4'd0) ? m_sts_error : err_reg;
    end

    // Parent FSM. Segment pointers move forward when a segment is loaded
    // into the output register. The register holds its value while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            src_ptr        <= '0;
            dst_ptr        <= '0;
            rem            <= '0;
            tag_reg        <= '0;
            sel_reg        <= '0;
            err_reg        <= '0;
            cnt            <= '0;
            s_req_ready    <= 1'b0;
            s_sts_tag      <= '0;
            s_sts_error    <= '0;
            s_sts_valid    <= 1'b0;
            m_req_src_addr <= '0;
            m_req_src_sel  <= '0;
            m_req_dst_addr <= '0;
            m_req_len      <= '0;
            m_req_tag      <= '0;
            m_req_valid    <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            err_reg     <= err_next;
            s_sts_valid <= 1'b0;
            case (state)
                IDLE: begin
                    s_req_ready <= 1'b1;
                    if (s_req_valid && s_req_ready) begin
                        src_ptr     <= s_req_src_addr;
                        dst_ptr     <= s_req_dst_addr;
                        rem         <= s_req_len;
                        tag_reg     <= s_req_tag;
                        sel_reg     <= s_req_src_sel;
                        err_reg     <= 4'd0;
                        s_req_ready <= 1'b0;
                        if (s_req_len == '0) begin
                            state       <= DONE;
                            s_sts_valid <= 1'b1;
                            s_sts_tag   <= s_req_tag;
                            s_sts_error <= 4'd0;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!m_req_valid || m_req_ready) begin
                        if (rem != '0 && cnt_next < CNT_W'(MAX_OUTSTANDING)) begin
                            m_req_src_addr <= src_ptr;
                            m_req_dst_addr <= dst_ptr;
                            m_req_len      <= LEN_W'(seg);
                            m_req_tag      <= tag_reg;
                            m_req_src_sel  <= sel_reg;
                            m_req_valid    <= 1'b1;
                            src_ptr        <= src_ptr + SRC_ADDR_W'(seg);
                            dst_ptr        <= dst_ptr + DST_ADDR_W'(seg);
                            rem            <= rem - LEN_W'(seg);
                        end else begin
                            m_req_valid <= 1'b0;
                            if (rem == '0) state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_next == '0) begin
                        state       <= DONE;
                        s_sts_valid <= 1'b1;
                        s_sts_tag   <= tag_reg;
                        s_sts_error <= err_next;
                    end
                end
                default: begin
                    state       <= IDLE;
                    s_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_taxi_dma_wr_desc_split.sv
// Bench for taxi_dma_wr_desc_split. A behavioural model builds the list of
// expected segments from the boundary rule. A downstream responder stalls
// at random and returns statuses. Every comparison is an immediate assertion.
module tb_taxi_dma_wr_desc_split;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_req_src_addr = '0;
    logic [1:0]  s_req_src_sel = '0;
    logic [15:0] s_req_dst_addr = '0;
    logic [15:0] s_req_len = '0;
    logic [7:0]  s_req_tag = '0;
    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic [7:0]  s_sts_tag;
    logic [3:0]  s_sts_error;
    logic        s_sts_valid;
    logic [15:0] m_req_src_addr;
    logic [1:0]  m_req_src_sel;
    logic [15:0] m_req_dst_addr;
    logic [15:0] m_req_len;
    logic [7:0]  m_req_tag;
    logic        m_req_valid;
    logic        m_req_ready = 1'b0;
    logic [3:0]  m_sts_error = '0;
    logic        m_sts_valid = 1'b0;

    always #5 clk = ~clk;

    taxi_dma_wr_desc_split dut (
        .clk(clk), .rst(rst),
        .s_req_src_addr(s_req_src_addr), .s_req_src_sel(s_req_src_sel),
        .s_req_dst_addr(s_req_dst_addr), .s_req_len(s_req_len),
        .s_req_tag(s_req_tag), .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_sts_tag(s_sts_tag), .s_sts_error(s_sts_error), .s_sts_valid(s_sts_valid),
        .m_req_src_addr(m_req_src_addr), .m_req_src_sel(m_req_src_sel),
        .m_req_dst_addr(m_req_dst_addr), .m_req_len(m_req_len),
        .m_req_tag(m_req_tag), .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_sts_error(m_sts_error), .m_sts_valid(m_sts_valid)
    );

    int vectors = 0, miscompares = 0;
    int cyc = 0, inflight = 0, issued = 0, sts_seen = 0, sts_cyc = 0, acc_cyc = 0;
    bit sts_en = 0, ready_all = 0, force_sts = 0, stale_sts = 0, rnd_err = 0;
    logic [15:0] q_src[$], q_dst[$], q_len[$];
    logic [3:0]  err_q[$];
    logic [7:0]  cur_tag = '0, obs_tag = '0;
    logic [1:0]  cur_sel = '0;
    logic [3:0]  cur_err = '0, obs_err = '0;
    bit          pv = 0, pr = 0;
    logic [57:0] pfields = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference segmentation: cut at each 4096-byte destination boundary.
    task automatic build_exp(input int src, input int dst, input int len);
        int rem, seg, s, d;
        rem = len; s = src; d = dst;
        while (rem > 0) begin
            seg = 4096 - (d % 4096);
            if (rem < seg) seg = rem;
            q_src.push_back(16'(s));
            q_dst.push_back(16'(d));
            q_len.push_back(16'(seg));
            s = (s + seg) % 65536;
            d = (d + seg) % 65536;
            rem -= seg;
        end
    endtask

    // One clock. Observe at the negedge, drive the responder, then step.
    task automatic cycle();
        logic [3:0] e;
        logic [57:0] fields;
        fields = {m_req_src_addr, m_req_dst_addr, m_req_len, m_req_tag, m_req_src_sel};
        if (pv && !pr) chk("stall_hold", {m_req_valid, fields}, {1'b1, pfields});
        if (s_sts_valid === 1'b1) begin
            sts_seen++;
            sts_cyc = cyc;
            obs_tag = s_sts_tag;
            obs_err = s_sts_error;
            chk("parent_sts", {s_sts_tag, s_sts_error}, {cur_tag, cur_err});
        end
        m_sts_valid = 1'b0;
        m_sts_error = 4'd0;
        if (stale_sts) begin
            m_sts_valid = 1'b1;
            m_sts_error = 4'd4;
            stale_sts = 0;
        end else if (inflight > 0 && (force_sts || (sts_en && $urandom_range(0, 2) == 0))) begin
            if (err_q.size() > 0) e = err_q.pop_front();
            else if (rnd_err && $urandom_range(0, 3) == 0) e = 4'($urandom_range(1, 15));
            else e = 4'd0;
            m_sts_valid = 1'b1;
            m_sts_error = e;
            inflight--;
            if (cur_err == 4'd0) cur_err = e;
            force_sts = 0;
        end
        m_req_ready = ready_all ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (m_req_valid && m_req_ready) begin
            if (q_src.size() == 0) begin
                chk("unexpected_seg", 1, 0);
            end else begin
                chk("seg", fields, {q_src.pop_front(), q_dst.pop_front(), q_len.pop_front(),
                                    cur_tag, cur_sel});
            end
            inflight++;
            issued++;
            chk("outstanding_le_max", (inflight <= 4), 1);
        end
        pv = m_req_valid;
        pr = m_req_ready;
        pfields = fields;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_parent(input int src, input int dst, input int len,
                                input logic [7:0] tag, input logic [1:0] sel);
        bit acc;
        int n;
        build_exp(src, dst, len);
        cur_tag = tag; cur_sel = sel; cur_err = 4'd0;
        s_req_src_addr = 16'(src); s_req_dst_addr = 16'(dst);
        s_req_len = 16'(len); s_req_tag = tag; s_req_src_sel = sel;
        s_req_valid = 1'b1;
        n = 0;
        do begin
            acc = (s_req_ready === 1'b1);
            cycle();
            n++;
        end while (!acc && n < 100);
        s_req_valid = 1'b0;
        acc_cyc = cyc;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n0, n;
        n0 = sts_seen; n = 0;
        while (sts_seen == n0 && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_one_status"}, 64'(sts_seen - n0), 1);
        chk({name, "_segs_left"}, 64'(q_src.size()), 0);
        chk({name, "_inflight"}, 64'(inflight), 0);
    endtask

    initial begin
        int i0, n;
        repeat (3) @(negedge clk);
        chk("rst_s_side", {s_req_ready, s_sts_valid, s_sts_tag, s_sts_error}, 0);
        chk("rst_m_side", {m_req_valid, m_req_src_addr, m_req_dst_addr, m_req_len,
                           m_req_tag, m_req_src_sel}, 0);
        rst = 1'b0;
        @(negedge clk);
        sts_en = 1;

        // 1: a single short segment
        start_parent(16'h0200, 16'h0010, 100, 8'd7, 2'd1);
        wait_done("t1", 2000);
        chk("t1_sts", {obs_tag, obs_err}, {8'd7, 4'd0});

        // 2: starts off-boundary, four segments
        i0 = issued;
        start_parent(0, 16'h0F00, 10000, 8'd2, 2'd2);
        wait_done("t2", 4000);
        chk("t2_nseg", 64'(issued - i0), 4);

        // 3: in-flight limit
        sts_en = 0; ready_all = 1; i0 = issued;
        start_parent(16'h1234, 0, 20000, 8'd3, 2'd0);
        repeat (30) cycle();
        chk("t3_four_issued", 64'(issued - i0), 4);
        chk("t3_valid_low", m_req_valid, 0);
        force_sts = 1;
        n = 0;
        while (issued - i0 < 5 && n < 20) begin cycle(); n++; end
        chk("t3_fifth", 64'(issued - i0), 5);
        sts_en = 1; ready_all = 0;
        wait_done("t3", 4000);

        // 4: the first nonzero error is kept
        err_q = '{4'd0, 4'd3, 4'd5};
        start_parent(16'h0040, 0, 12288, 8'd4, 2'd3);
        wait_done("t4", 4000);
        chk("t4_err", obs_err, 3);

        // 5: a zero-length parent reports on the cycle after it is accepted
        i0 = issued;
        start_parent(16'h0100, 16'h0100, 0, 8'd9, 2'd0);
        wait_done("t5", 50);
        chk("t5_latency", 64'(sts_cyc), 64'(acc_cyc));
        chk("t5_sts", {obs_tag, obs_err}, {8'd9, 4'd0});
        chk("t5_noseg", 64'(issued - i0), 0);

        // destination address wraps past 0xFFFF
        start_parent(16'hFF00, 16'hFFF0, 300, 8'h5A, 2'd1);
        wait_done("wrap", 2000);

        // random parents with random errors
        rnd_err = 1;
        for (int k = 0; k < 8; k++) begin
            start_parent($urandom_range(0, 65535), $urandom_range(0, 65535),
                         (k % 3 == 0) ? $urandom_range(1, 64) : $urandom_range(1, 12000),
                         8'($urandom), 2'($urandom));
            wait_done("rand", 6000);
        end
        rnd_err = 0;

        // 6: reset in the middle of a parent, then a stale status
        sts_en = 0; ready_all = 1; i0 = issued;
        start_parent(0, 0, 16384, 8'h33, 2'd1);
        n = 0;
        while (issued - i0 < 2 && n < 50) begin cycle(); n++; end
        rst = 1'b1;
        #1;
        chk("t6_rst_s_side", {s_req_ready, s_sts_valid, s_sts_tag, s_sts_error}, 0);
        chk("t6_rst_m_side", {m_req_valid, m_req_src_addr, m_req_dst_addr, m_req_len,
                              m_req_tag, m_req_src_sel}, 0);
        q_src.delete(); q_dst.delete(); q_len.delete();
        inflight = 0; pv = 0; m_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ready_all = 0;
        cycle();
        stale_sts = 1;
        cycle();
        chk("t6_after_stale", {m_req_valid, s_sts_valid}, 0);
        sts_en = 1;
        start_parent(16'h0800, 16'h0020, 64, 8'h44, 2'd2);
        wait_done("t6", 2000);
        chk("t6_sts", {obs_tag, obs_err}, {8'h44, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
